// File: rtl/regf_wb_if.sv
// Port bundle for regf_wb_queue: ALU/load producers, the register-file write port,
// and the hazard/forwarding query lines. The queue takes the slave side.
interface regf_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  alu_valid;
    logic [4:0]            alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [4:0]            ld_rd;
    logic [DATA_WIDTH-1:0] ld_data;

    logic                  we3;
    logic [4:0]            a3;
    logic [DATA_WIDTH-1:0] wd3;

    logic [4:0]            chk1;
    logic [4:0]            chk2;
    logic                  busy1;
    logic                  busy2;

    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;

    logic                  fwd1_hit;
    logic                  fwd2_hit;
    logic [DATA_WIDTH-1:0] fwd1_data;
    logic [DATA_WIDTH-1:0] fwd2_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output chk1, chk2,
        input  ld_ready,
        input  we3, a3, wd3,
        input  busy1, busy2,
        input  count, full, empty,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  chk1, chk2,
        output ld_ready,
        output we3, a3, wd3,
        output busy1, busy2,
        output count, full, empty,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );
endinterface

// File: rtl/regf_wb_queue.sv
// Write-back queue owning the register-file write port: ALU has a fixed slot, load results
// are buffered and drained into idle cycles. Define REGF_WBQ_FWD_EN to enable forwarding.
module regf_wb_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic        clk,
    input logic        rst_n,
    regf_wb_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Write-port output register
    logic                  we3_q, we3_d;
    logic [4:0]            a3_q, a3_d;
    logic [DATA_WIDTH-1:0] wd3_q, wd3_d;

    // FIFO control
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // FIFO storage
    logic [4:0]            rd_mem_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

    logic                  full;
    logic                  empty;
    logic                  alu_take;
    logic                  pop;
    logic                  push;
    logic                  store;
    logic [DEPTH-1:0]      ent_vld;
    logic                  busy1;
    logic                  busy2;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // ld_ready looks only at registered occupancy, so a full queue never passes a load through.
    assign push     = bus.ld_valid && !full;
    assign store    = push && (bus.ld_rd != 5'd0);
    assign alu_take = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign pop      = !alu_take && !empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        we3_d   = 1'b0;
        a3_d    = a3_q;
        wd3_d   = wd3_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (alu_take) begin
            we3_d = 1'b1;
            a3_d  = bus.alu_rd;
            wd3_d = bus.alu_data;
        end else if (pop) begin
            we3_d = 1'b1;
            a3_d  = rd_mem_q[head_q];
            wd3_d = data_mem_q[head_q];
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (store) begin
            tail_d = tail_q + PTR_W'(1);
        end

        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q   <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is not reset; head/tail/count define which slots hold live data.
    always_ff @(posedge clk) begin
        if (store) begin
            rd_mem_q[tail_q]   <= bus.ld_rd;
            data_mem_q[tail_q] <= bus.ld_data;
        end
    end

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        ent_vld = '0;
        for (int k = 0; k < DEPTH; k++) begin : g_vld
            logic [PTR_W-1:0] idx;
            idx          = head_q + PTR_W'(k);
            ent_vld[idx] = (CNT_W'(k) < count_q);
        end
    end

    always_comb begin
        busy1 = we3_q && (a3_q == bus.chk1);
        busy2 = we3_q && (a3_q == bus.chk2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (rd_mem_q[i] == bus.chk1)) busy1 = 1'b1;
            if (ent_vld[i] && (rd_mem_q[i] == bus.chk2)) busy2 = 1'b1;
        end
        if (bus.chk1 == 5'd0) busy1 = 1'b0;
        if (bus.chk2 == 5'd0) busy2 = 1'b0;
    end

`ifdef REGF_WBQ_FWD_EN
    logic [DATA_WIDTH-1:0] fwd1_val;
    logic [DATA_WIDTH-1:0] fwd2_val;

    // Walk oldest to youngest so the entry nearest the tail wins; the output register is oldest.
    always_comb begin
        fwd1_val = '0;
        fwd2_val = '0;
        if (we3_q && (a3_q == bus.chk1)) fwd1_val = wd3_q;
        if (we3_q && (a3_q == bus.chk2)) fwd2_val = wd3_q;
        for (int k = 0; k < DEPTH; k++) begin : g_fwd
            logic [PTR_W-1:0] idx;
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (rd_mem_q[idx] == bus.chk1)) fwd1_val = data_mem_q[idx];
            if ((CNT_W'(k) < count_q) && (rd_mem_q[idx] == bus.chk2)) fwd2_val = data_mem_q[idx];
        end
    end

    assign bus.fwd1_hit  = busy1;
    assign bus.fwd2_hit  = busy2;
    assign bus.fwd1_data = busy1 ? fwd1_val : '0;
    assign bus.fwd2_data = busy2 ? fwd2_val : '0;
`else
    assign bus.fwd1_hit  = 1'b0;
    assign bus.fwd2_hit  = 1'b0;
    assign bus.fwd1_data = '0;
    assign bus.fwd2_data = '0;
`endif

    assign bus.we3      = we3_q;
    assign bus.a3       = a3_q;
    assign bus.wd3      = wd3_q;
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.ld_ready = !full;
    assign bus.busy1    = busy1;
    assign bus.busy2    = busy2;

endmodule

// File: tb/tb_regf_wb_queue.sv
// Self-checking bench for regf_wb_queue: directed steps plus random traffic, compared
// against a queue-based model of the write-back rules.
module tb_regf_wb_queue;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regf_wb_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    regf_wb_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: pending loads in arrival order plus the current write-port value.
    wr_t           q[$];
    logic          m_we;
    logic [4:0]    m_a3;
    logic [DW-1:0] m_wd;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_we = 1'b0;
        m_a3 = '0;
        m_wd = '0;
    endtask

    function automatic logic m_pending(input logic [4:0] c);
        logic hit;
        hit = m_we && (m_a3 == c);
        foreach (q[i]) if (q[i].rd == c) hit = 1'b1;
        return hit && (c != 5'd0);
    endfunction

    function automatic logic [DW-1:0] m_fwd(input logic [4:0] c);
        logic [DW-1:0] v;
        v = '0;
        if (!m_pending(c)) return '0;
        if (m_we && (m_a3 == c)) v = m_wd;
        foreach (q[i]) if (q[i].rd == c) v = q[i].data;
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":we3"},      bus.we3, m_we);
        check({tag, ":a3"},       bus.a3, m_a3);
        check({tag, ":wd3"},      bus.wd3, m_wd);
        check({tag, ":count"},    bus.count, q.size());
        check({tag, ":full"},     bus.full, q.size() == DEPTH);
        check({tag, ":empty"},    bus.empty, q.size() == 0);
        check({tag, ":ld_ready"}, bus.ld_ready, q.size() < DEPTH);
        check({tag, ":busy1"},    bus.busy1, m_pending(bus.chk1));
        check({tag, ":busy2"},    bus.busy2, m_pending(bus.chk2));
`ifdef REGF_WBQ_FWD_EN
        check({tag, ":fwd1_hit"},  bus.fwd1_hit, m_pending(bus.chk1));
        check({tag, ":fwd2_hit"},  bus.fwd2_hit, m_pending(bus.chk2));
        check({tag, ":fwd1_data"}, bus.fwd1_data, m_fwd(bus.chk1));
        check({tag, ":fwd2_data"}, bus.fwd2_data, m_fwd(bus.chk2));
`else
        check({tag, ":fwd1_hit"},  bus.fwd1_hit, 1'b0);
        check({tag, ":fwd2_hit"},  bus.fwd2_hit, 1'b0);
        check({tag, ":fwd1_data"}, bus.fwd1_data, '0);
        check({tag, ":fwd2_data"}, bus.fwd2_data, '0);
`endif
    endtask

    // One clock: sample inputs, advance the model at posedge, compare at the following negedge.
    task automatic cycle(input string tag);
        logic          take, store;
        logic [4:0]    arv, lrd;
        logic [DW-1:0] adv, ldv;
        wr_t           e;
        take  = bus.alu_valid && (bus.alu_rd != 5'd0);
        store = bus.ld_valid && (q.size() < DEPTH) && (bus.ld_rd != 5'd0);
        arv   = bus.alu_rd;
        adv   = bus.alu_data;
        lrd   = bus.ld_rd;
        ldv   = bus.ld_data;
        @(posedge clk);
        if (take) begin
            m_we = 1'b1; m_a3 = arv; m_wd = adv;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            m_we = 1'b1; m_a3 = e.rd; m_wd = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (store) begin
            e.rd = lrd; e.data = ldv;
            q.push_back(e);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
        bus.chk1      = '0;
        bus.chk2      = '0;
        m_reset();

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        check("reset_we3", bus.we3, 1'b0);
        check("reset_empty", bus.empty, 1'b1);
        check("reset_ld_ready", bus.ld_ready, 1'b1);
        rst_n = 1'b1;
        cycle("post_reset");

        // ALU path, then ALU to x0 dropped
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        bus.chk1 = 5'd5;
        cycle("alu");
        check("alu_we3", bus.we3, 1'b1);
        check("alu_a3", bus.a3, 5'd5);
        check("alu_wd3", bus.wd3, 32'hDEAD_BEEF);
        check("alu_busy", bus.busy1, 1'b1);
        bus.alu_rd = 5'd0;
        cycle("alu_x0");
        check("alu_x0_we3", bus.we3, 1'b0);
        bus.alu_valid = 1'b0;

        // Loads with ALU idle: each write lands one cycle after the push is visible
        for (int i = 1; i <= 4; i++) begin
            bus.ld_valid = 1'b1; bus.ld_rd = 5'(i); bus.ld_data = 32'(i * 'h11);
            cycle("ld_fill");
            check("ld_cnt_le1", bus.count <= 1, 1'b1);
            if (i > 1) check("ld_order_a3", bus.a3, 5'(i - 1));
        end
        bus.ld_valid = 1'b0;
        cycle("ld_tail");
        check("ld_last_a3", bus.a3, 5'd4);
        check("ld_last_wd3", bus.wd3, 32'h44);
        cycle("ld_idle");

        // Starve with ALU, fill, then drain; three rounds wrap the pointers
        for (int r = 0; r < 3; r++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'(r);
            bus.chk1 = 5'd3;
            for (int i = 0; i < 4; i++) begin
                bus.ld_valid = 1'b1; bus.ld_rd = 5'(3 + i); bus.ld_data = 32'(100 * r + i);
                cycle("fill");
            end
            bus.ld_valid = 1'b0;
            check("full_flag", bus.full, 1'b1);
            check("full_ld_ready", bus.ld_ready, 1'b0);
            check("full_busy_r3", bus.busy1, 1'b1);
            bus.alu_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                cycle("drain");
                check("drain_a3", bus.a3, 5'(3 + i));
                check("drain_wd3", bus.wd3, 32'(100 * r + i));
            end
            check("drain_empty", bus.empty, 1'b1);
        end

        // Push and pop in the same cycle with two entries queued
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_data = 32'h100;
        cycle("pp_fill");
        bus.ld_rd = 5'd11; bus.ld_data = 32'h101;
        cycle("pp_fill");
        check("pp_count2", bus.count, 2);
        bus.alu_valid = 1'b0;
        bus.ld_rd = 5'd12; bus.ld_data = 32'h102;
        cycle("pp_both");
        check("pp_count_held", bus.count, 2);
        check("pp_a3", bus.a3, 5'd10);
        bus.ld_valid = 1'b0;
        cycle("pp_drain");
        check("pp_a3_2", bus.a3, 5'd11);
        cycle("pp_drain");
        check("pp_a3_3", bus.a3, 5'd12);

        // Two queued writes to the same register: youngest value forwards
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.chk1 = 5'd9;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'hA;
        cycle("fwd_q");
        bus.ld_data = 32'hB;
        cycle("fwd_q");
        bus.ld_valid = 1'b0;
`ifdef REGF_WBQ_FWD_EN
        check("fwd_hit", bus.fwd1_hit, 1'b1);
        check("fwd_data", bus.fwd1_data, 32'hB);
`else
        check("fwd_hit_off", bus.fwd1_hit, 1'b0);
        check("fwd_data_off", bus.fwd1_data, 32'h0);
`endif
        bus.alu_valid = 1'b0;
        repeat (3) cycle("fwd_drain");

        // Random traffic: light then heavy ALU load, small register range for collisions
        for (int n = 0; n < 400; n++) begin
            bus.alu_valid = ($urandom_range(0, 99) < ((n < 200) ? 40 : 85));
            bus.alu_rd    = 5'($urandom_range(0, 7));
            bus.alu_data  = $urandom;
            bus.ld_valid  = 1'($urandom_range(0, 1));
            bus.ld_rd     = 5'($urandom_range(0, 7));
            bus.ld_data   = $urandom;
            bus.chk1      = 5'($urandom_range(0, 7));
            bus.chk2      = 5'($urandom_range(0, 7));
            cycle("rnd");
        end

        // Asynchronous reset mid-cycle with the port busy and entries queued
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h55;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h66;
        cycle("arst_pre");
        cycle("arst_pre");
        check("arst_pre_we3", bus.we3, 1'b1);
        bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("arst_we3", bus.we3, 1'b0);
        check("arst_count", bus.count, 0);
        check("arst_empty", bus.empty, 1'b1);
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("arst_post");
        check("arst_post_we3", bus.we3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regf_wb_queue.md
# regf_wb_queue

Write-back queue that owns the single register-file write port (we3/a3/wd3) and merges results from two producers: the ALU, which has a fixed slot, and the load unit, which is elastic. Load results are buffered in a small FIFO and drained into free write-port cycles. Per-register busy flags feed the hazard unit. The block sits between the execute/memory stages and `regf`, and is the writer end of `regf`'s write interface.

## Interface
- `DATA_WIDTH`, 32, width of written data.
- `DEPTH`, 4, load FIFO entries; power of two, ≥2.
- `clk` in 1: single clock. All state updates on posedge; `regf` captures on the following negedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result valid this cycle; always accepted, with no ready.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in DATA_WIDTH: ALU result.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: queue can accept a load result.
- `ld_rd` in 5: load destination register.
- `ld_data` in DATA_WIDTH: load result.
- `we3` out 1: register-file write enable.
- `a3` out 5: register-file write address.
- `wd3` out DATA_WIDTH: register-file write data.
- `chk1`, `chk2` in 5: register indices queried by the hazard unit.
- `busy1`, `busy2` out 1: the queried register has a pending write.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `full`, `empty` out 1: FIFO status.
- `fwd1_hit`, `fwd2_hit` out 1: forwarding hit (see Configuration).
- `fwd1_data`, `fwd2_data` out DATA_WIDTH: forwarded value (see Configuration).

## Operation
- **Load push:** on `ld_valid && ld_ready`.
  - `ld_rd != 0`: the entry {rd, data} is written at the tail.
  - `ld_rd == 0`: the handshake completes and nothing is stored.
- **`ld_ready`:** equals `!full`, derived from registered `count` only. There is no same-cycle pass-through when the FIFO is full.
- **Write-port arbitration at each posedge, in priority order:**
  1. `alu_valid && alu_rd != 0`: {we3,a3,wd3} ← {1, alu_rd, alu_data}. The FIFO is not popped.
  2. Otherwise, if `!empty`: {we3,a3,wd3} ← {1, head.rd, head.data}, and the head is popped.
  3. Otherwise: `we3` ← 0, and `a3`/`wd3` hold their values.
- **ALU with `alu_rd == 0`:** dropped. The FIFO may drain in that cycle.
- **Push and pop in the same cycle:** both take effect and `count` is unchanged.
- **Pointers:** $clog2(DEPTH)-bit pointers wrap modulo DEPTH. `count` ranges 0..DEPTH. `full` = (count == DEPTH); `empty` = (count == 0).
- **Busy flags:** `busyN` = `chkN != 0` && (any valid FIFO entry has rd == chkN || (we3 && a3 == chkN)). Combinational from state only; independent of the current cycle's `alu_*`/`ld_*`.
- **Ordering:** the block does not reorder same-rd writes between producers. Upstream stalls on `busyN` to prevent a younger ALU write overtaking an older queued load to the same rd.

## Timing
- **Reset (asynchronous, immediate on `rst_n` low):**
  - `we3`=0, `a3`=0, `wd3`=0.
  - Pointers 0, `count`=0, `empty`=1, `full`=0, `ld_ready`=1.
  - `busy*`=0, `fwd*_hit`=0, `fwd*_data`=0.
- **Reset mid-operation:** all queued entries are discarded, and `we3` drops within the same cycle.
- **ALU latency:** `alu_valid` sampled at edge N → `we3` high after edge N → `regf` written at the negedge of that cycle.
- **Load latency (ALU idle):** accepted at edge N → at head after N → `we3` high after edge N+1.
- **Starvation:** continuous ALU traffic starves the FIFO. `ld_ready` falls once DEPTH entries are queued.
- **`count`/`full`/`empty`/`ld_ready`:** update only on posedge.

## Configuration
- **`REGF_WBQ_FWD_EN` defined:**
  - `fwdN_hit` = `chkN != 0` and a pending write to `chkN` exists.
  - `fwdN_data` = the value of the youngest pending write: the youngest matching FIFO entry (nearest tail) first, then the output register (we3 && a3 == chkN).
  - Combinational.
- **Undefined:** `fwd*_hit`=0 and `fwd*_data`=0 constantly. No match or mux logic is synthesized; the ports remain present.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release. Expect `we3`=0, `count`=0, `empty`=1, `ld_ready`=1. Then assert `rst_n`=0 mid-cycle while `we3`=1; `we3` must fall without waiting for a clock edge.
- **ALU path:** `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF for one cycle. Expect `we3`=1, `a3`=5, `wd3`=0xDEADBEEF in the next cycle. Then `alu_rd`=0 with `alu_valid`=1; `we3` must stay 0.
- **Load fill/drain:** with ALU idle, push loads rd=1..4, data 0x11..0x44, on consecutive cycles, draining concurrently. Expect writes 1..4 in order, each 2 cycles after its push, and `count` never exceeding 1.
- **Full and back-pressure:** hold `alu_valid`=1 (rd=7) and push 4 loads. Expect `full`=1, `ld_ready`=0, and `busy1`=1 for `chk1`=3. Drop ALU; expect 4 FIFO writes, then `empty`=1. Repeat across 3 fill/drain rounds to exercise pointer wrap.
- **Simultaneous push/pop:** with `count`=2, push one load while a pop occurs. `count` stays 2, and the write order is preserved.
- **Forwarding (`REGF_WBQ_FWD_EN`):** queue rd=9 with 0xA, then rd=9 with 0xB, with `chk1`=9. Expect `fwd1_hit`=1 and `fwd1_data`=0xB. Without the macro, expect `fwd1_hit`=0.
